uc_engine_rr_sched: RTL and testbench

- Round-robin scheduler sharing the unit-clause broadcast path between the memory loader and NUM_ENGINE BCP engines.
- During the initial phase it forwards unit literals streamed from memory. After that it selects one non-empty engine output queue per grant, pops it and registers the literal.
- It broadcasts the literal to all engines, stalling while any engine input queue is full.
- It flags a conflict when two consecutively scheduled literals are complementary.

---
 rtl/uc_engine_rr_sched_pkg.sv | 25 ++
 rtl/uc_engine_rr_sched_rr_pick.sv | 32 +++
 rtl/uc_engine_rr_sched.sv | 130 +++++++++++++
 tb/tb_uc_engine_rr_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_engine_rr_sched_pkg.sv
// Shared types for the unit-clause broadcast scheduler: literal width,
// signed literal type, scheduler states and the complement test.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

package uc_pkg;

    // Signed literal: magnitude is a variable index, sign is polarity, 0 = none
    localparam int LIT_W = $clog2(`LIT_IDX_MAX) + 1;

    typedef logic signed [LIT_W-1:0] lit_t;

    typedef enum logic [1:0] {
        S_MEM  = 2'd0,
        S_ENG  = 2'd1,
        S_HALT = 2'd2
    } sched_state_e;

    // Two nonzero literals of opposite polarity on the same variable
    function automatic logic lits_conflict(input lit_t lit, input lit_t prev);
        return (lit != '0) && (prev != '0) && (lit == -prev);
    endfunction

endpackage

// File: rtl/uc_engine_rr_sched_rr_pick.sv
// Rotate-priority picker: the first requester at or after ptr (wrapping)
// wins. Purely combinational so the grant can pop in the same cycle.
module uc_rr_pick #(
    parameter int NUM_ENGINE = 4,
    parameter int PTR_W      = 2
) (
    input  logic [NUM_ENGINE-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [NUM_ENGINE-1:0] gnt,
    output logic [PTR_W-1:0]      gnt_idx,
    output logic                  any
);

    logic [PTR_W-1:0] idx;

    // Walk the requesters starting at ptr and keep the first hit
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_ENGINE);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uc_engine_rr_sched.sv
// Round-robin scheduler for the unit-clause broadcast path. Forwards the
// memory loader's unit literals first, then serves the engine output queues
// in rotation, broadcasting each literal through a one-entry output slot
// and halting on the first pair of complementary consecutive literals.
module uc_engine_rr_sched
    import uc_pkg::*;
#(
    parameter int NUM_ENGINE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem2uca_valid,
    input  logic                          mem2uca_done,
    input  logic signed [LIT_W-1:0]       mem2uca,
    output logic                          uca2mem_ready,
    input  logic [NUM_ENGINE*LIT_W-1:0]   eng2uca_lit,
    input  logic [NUM_ENGINE-1:0]         eng2uca_valid,
    input  logic [NUM_ENGINE-1:0]         eng2uca_empty,
    input  logic [NUM_ENGINE-1:0]         uca2eng_full,
    output logic [NUM_ENGINE-1:0]         uca2eng_pop,
    output logic signed [LIT_W-1:0]       uca2eng,
    output logic                          uca2eng_valid,
    output logic                          conflict,
    output logic                          sched_idle
);

    localparam int PTR_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    sched_state_e          state;
    logic [PTR_W-1:0]      ptr;
    lit_t                  prev_lit;

    lit_t                  eng_lit [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] req;
    logic [NUM_ENGINE-1:0] gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  any_req;

    logic                  any_full;
    logic                  accept;
    logic                  slot_free;
    logic                  grant;
    logic                  mem_load;
    logic                  eng_load;
    logic                  load;
    lit_t                  load_lit;
    logic                  hit_conflict;
    logic                  mem_exit;

    for (genvar i = 0; i < NUM_ENGINE; i++) begin : g_unpack
        assign eng_lit[i] = eng2uca_lit[i*LIT_W +: LIT_W];
    end

    uc_rr_pick #(
        .NUM_ENGINE (NUM_ENGINE),
        .PTR_W      (PTR_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // Slot handshake, grant decision and the literal chosen for loading.
    // An engine grant also waits out a full engine even when the slot is
    // empty, so nothing is popped while the broadcast path is blocked.
    always_comb begin
        any_full     = |uca2eng_full;
        accept       = uca2eng_valid && !any_full;
        slot_free    = !uca2eng_valid || accept;
        req          = ~eng2uca_empty;
        grant        = (state == S_ENG) && slot_free && !any_full && any_req;
        mem_load     = (state == S_MEM) && mem2uca_valid && slot_free;
        eng_load     = grant && eng2uca_valid[gnt_idx];
        load         = mem_load || eng_load;
        load_lit     = mem_load ? mem2uca : eng_lit[gnt_idx];
        hit_conflict = load && lits_conflict(load_lit, prev_lit);
        // Leave the memory phase only once a literal offered alongside done
        // has actually been taken, so it is never dropped.
        mem_exit     = (state == S_MEM) && mem2uca_done && (!mem2uca_valid || slot_free);
    end

    // Handshakes toward memory and engines act in the deciding cycle; reset wins
    always_comb begin
        uca2mem_ready = (state == S_MEM) && slot_free && !rst;
        uca2eng_pop   = (grant && !rst) ? gnt : '0;
    end

    // Phase FSM together with slot, pointer, last literal, conflict and idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_MEM;
            ptr           <= '0;
            uca2eng       <= '0;
            uca2eng_valid <= 1'b0;
            prev_lit      <= '0;
            conflict      <= 1'b0;
            sched_idle    <= 1'b0;
        end else begin
            sched_idle <= (state == S_ENG) && (&eng2uca_empty) && !uca2eng_valid;

            if (load) begin
                uca2eng       <= load_lit;
                uca2eng_valid <= 1'b1;
            end else if (accept) begin
                uca2eng_valid <= 1'b0;
            end

            if (load && (load_lit != '0)) begin
                prev_lit <= load_lit;
            end

            if (grant) begin
                ptr <= (gnt_idx == PTR_W'(NUM_ENGINE - 1)) ? '0 : gnt_idx + 1'b1;
            end

            case (state)
                S_MEM:   if (mem_exit) state <= S_ENG;
                default: state <= state;
            endcase

            if (hit_conflict) begin
                conflict <= 1'b1;
                state    <= S_HALT;
            end
        end
    end

endmodule

// File: tb/tb_uc_engine_rr_sched.sv
// Scoreboard bench for uc_engine_rr_sched: engines and memory are modelled
// as literal queues, a transaction-level reference decides each cycle's
// pops and loads, and a separate monitor checks every accepted broadcast.
module tb_uc_engine_rr_sched;
    import uc_pkg::*;

    localparam int NE = 4;
    localparam int NW = NE * LIT_W;
    localparam int PH_MEM  = 0;
    localparam int PH_ENG  = 1;
    localparam int PH_HALT = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    mem2uca_valid = 1'b0;
    logic                    mem2uca_done = 1'b0;
    logic signed [LIT_W-1:0] mem2uca = '0;
    logic                    uca2mem_ready;
    logic [NW-1:0]           eng2uca_lit = '0;
    logic [NE-1:0]           eng2uca_valid = '0;
    logic [NE-1:0]           eng2uca_empty = '1;
    logic [NE-1:0]           uca2eng_full = '0;
    logic [NE-1:0]           uca2eng_pop;
    logic signed [LIT_W-1:0] uca2eng;
    logic                    uca2eng_valid;
    logic                    conflict;
    logic                    sched_idle;

    uc_engine_rr_sched #(.NUM_ENGINE(NE)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem2uca_valid (mem2uca_valid),
        .mem2uca_done  (mem2uca_done),
        .mem2uca       (mem2uca),
        .uca2mem_ready (uca2mem_ready),
        .eng2uca_lit   (eng2uca_lit),
        .eng2uca_valid (eng2uca_valid),
        .eng2uca_empty (eng2uca_empty),
        .uca2eng_full  (uca2eng_full),
        .uca2eng_pop   (uca2eng_pop),
        .uca2eng       (uca2eng),
        .uca2eng_valid (uca2eng_valid),
        .conflict      (conflict),
        .sched_idle    (sched_idle)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int lit; } ent_t;

    ent_t eng_q [NE][$];
    int   mem_q [$];
    int   exp_q [$];

    bit            rand_mode   = 1'b0;
    bit            mem_done_en = 1'b0;
    bit            rst_next    = 1'b1;
    logic [NE-1:0] full_next   = '0;

    // Reference state (committed) and the decision for the current cycle
    int  m_phase = PH_MEM, m_ptr = 0, m_prev = 0, m_lit = 0;
    bit  m_valid = 0, m_conf = 0, m_idle = 0;
    int  n_phase, n_ptr, n_prev, n_lit;
    bit  n_valid, n_conf, n_idle;
    bit  pend_rst = 1'b1;
    int  pend_grant = -1;
    bit  pend_mem = 1'b0;
    logic [NE-1:0] exp_pop;
    bit  exp_ready;

    int checks = 0;
    int failures = 0;
    int halt_cycles = 0;

    task automatic compare(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    // Apply the previous cycle's decision to the environment and the model
    task automatic commit();
        if (pend_rst) begin
            m_phase = PH_MEM; m_ptr = 0; m_prev = 0; m_lit = 0;
            m_valid = 0; m_conf = 0; m_idle = 0;
            exp_q.delete();
        end else begin
            if (pend_grant >= 0) void'(eng_q[pend_grant].pop_front());
            if (pend_mem) void'(mem_q.pop_front());
            m_phase = n_phase; m_ptr = n_ptr; m_prev = n_prev; m_lit = n_lit;
            m_valid = n_valid; m_conf = n_conf; m_idle = n_idle;
        end
        pend_rst = 1'b0; pend_grant = -1; pend_mem = 1'b0;
    endtask

    // Drive DUT inputs from the queue heads and the requested full/reset
    task automatic applyStimulus();
        logic [NE-1:0]    emp, vld;
        logic [NW-1:0]    lits;
        logic [LIT_W-1:0] lb;
        rst           = rst_next;
        uca2eng_full  = full_next;
        mem2uca_valid = (mem_q.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
        mem2uca       = (mem_q.size() > 0) ? lit_t'(mem_q[0]) : '0;
        mem2uca_done  = mem_done_en && (mem_q.size() == 0 || (mem_q.size() == 1 && mem2uca_valid));
        emp = '0; vld = '0; lits = '0;
        for (int e = 0; e < NE; e++) begin
            if (eng_q[e].size() == 0) begin
                emp |= (NE'(1) << e);
            end else begin
                if (eng_q[e][0].v) vld |= (NE'(1) << e);
                lb   = LIT_W'(eng_q[e][0].lit);
                lits = lits | (NW'(lb) << (e * LIT_W));
            end
        end
        eng2uca_empty = emp;
        eng2uca_valid = vld;
        eng2uca_lit   = lits;
    endtask

    // Reference rules: what this cycle must pop, load and broadcast next
    task automatic decide();
        bit acc, sfree, ld, all_empty;
        int g, lv;
        exp_pop = '0; exp_ready = 1'b0; pend_grant = -1; pend_mem = 1'b0;
        n_phase = m_phase; n_ptr = m_ptr; n_prev = m_prev; n_lit = m_lit;
        n_valid = m_valid; n_conf = m_conf; n_idle = 1'b0;
        if (rst) begin
            pend_rst = 1'b1;
            return;
        end
        acc   = m_valid && (uca2eng_full == 0);
        sfree = !m_valid || acc;
        if (acc) n_valid = 1'b0;
        ld = 1'b0; lv = 0; g = -1;
        if (m_phase == PH_MEM) begin
            exp_ready = sfree;
            if (mem2uca_valid && sfree) begin
                ld = 1'b1; lv = mem_q[0]; pend_mem = 1'b1;
            end
            if (mem2uca_done && (!mem2uca_valid || sfree)) n_phase = PH_ENG;
        end else if (m_phase == PH_ENG && sfree && uca2eng_full == 0) begin
            for (int k = 0; k < NE; k++) begin
                if (g < 0 && eng_q[(m_ptr + k) % NE].size() > 0) g = (m_ptr + k) % NE;
            end
            if (g >= 0) begin
                exp_pop    = NE'(1) << g;
                pend_grant = g;
                n_ptr      = (g + 1) % NE;
                if (eng_q[g][0].v) begin
                    ld = 1'b1; lv = eng_q[g][0].lit;
                end
            end
        end
        if (ld) begin
            n_valid = 1'b1;
            n_lit   = lv;
            exp_q.push_back(lv);
            if (lv != 0) begin
                if (m_prev != 0 && lv == -m_prev) begin
                    n_conf  = 1'b1;
                    n_phase = PH_HALT;
                end
                n_prev = lv;
            end
        end
        all_empty = 1'b1;
        for (int e = 0; e < NE; e++) if (eng_q[e].size() > 0) all_empty = 1'b0;
        n_idle = (m_phase == PH_ENG) && all_empty && !m_valid;
    endtask

    task automatic checkOutput();
        compare("pop", int'(uca2eng_pop), int'(exp_pop));
        compare("mem_ready", int'(uca2mem_ready), int'(exp_ready));
        compare("conflict", int'(conflict), int'(m_conf));
        compare("slot_valid", int'(uca2eng_valid), int'(m_valid));
        if (m_valid) compare("slot_lit", int'(uca2eng), m_lit);
        compare("sched_idle", int'(sched_idle), int'(m_idle));
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        commit();
        applyStimulus();
        #1;
        decide();
        checkOutput();
    endtask

    task automatic push_eng(input int e, input bit v, input int lit);
        ent_t x;
        x.v = v; x.lit = lit;
        eng_q[e].push_back(x);
    endtask

    task automatic do_reset();
        rst_next = 1'b1;
        run_cycle();
        run_cycle();
        rst_next = 1'b0;
    endtask

    function automatic int rand_lit();
        int mag;
        mag = int'($urandom_range(1, 12));
        return ($urandom_range(0, 1) == 0) ? mag : -mag;
    endfunction

    // Monitor: every broadcast the engines accept must be the next expected
    always @(negedge clk) begin
        int e;
        if (rst === 1'b0 && uca2eng_valid === 1'b1 && uca2eng_full == 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL broadcast: got %0d expected none at %0t", int'(uca2eng), $time);
            end else begin
                e = exp_q.pop_front();
                if (int'(uca2eng) != e) begin
                    failures++;
                    $display("[TB] FAIL broadcast: got %0d expected %0d at %0t", int'(uca2eng), e, $time);
                end
            end
        end
    end

    initial begin
        do_reset();

        // Memory phase: 3, -5, 7 back to back, done alongside the last one
        mem_q = '{3, -5, 7};
        mem_done_en = 1'b1;
        repeat (4) run_cycle();

        // Round robin over engines 0, 1 and 3, then engine 3 alone
        push_eng(0, 1, 2); push_eng(1, 1, 4); push_eng(3, 1, 6);
        repeat (4) run_cycle();
        push_eng(3, 1, 11);
        run_cycle();

        // Backpressure from engine 2 while engine 1 waits with 9
        full_next = 4'b0100;
        push_eng(1, 1, 9);
        repeat (3) run_cycle();
        full_next = '0;
        repeat (3) run_cycle();

        // Head entry without a real literal is popped and dropped
        push_eng(2, 0, 0);
        repeat (3) run_cycle();

        // 8 followed by -8 raises conflict and freezes the engines
        push_eng(0, 1, 8); push_eng(0, 1, -8);
        repeat (4) run_cycle();
        push_eng(1, 1, 3); push_eng(2, 1, 5);
        repeat (6) run_cycle();

        // Reset while 5 is stalled in the slot
        for (int e = 0; e < NE; e++) eng_q[e].delete();
        do_reset();
        mem_q = '{5};
        run_cycle();
        full_next = 4'b0100;
        repeat (3) run_cycle();
        rst_next = 1'b1;
        run_cycle();
        rst_next = 1'b0;
        full_next = '0;
        repeat (4) run_cycle();

        // Randomised traffic, restarting whenever the scheduler has halted
        rand_mode = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if (halt_cycles > 6 || $urandom_range(0, 400) == 0) begin
                full_next = '0;
                do_reset();
                mem_q.delete();
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) mem_q.push_back(rand_lit());
                halt_cycles = 0;
            end
            full_next = ($urandom_range(0, 3) == 0) ? NE'($urandom_range(1, 15)) : '0;
            for (int e = 0; e < NE; e++) begin
                if (eng_q[e].size() < 3 && $urandom_range(0, 2) == 0)
                    push_eng(e, $urandom_range(0, 9) != 0, rand_lit());
            end
            run_cycle();
            halt_cycles = (m_phase == PH_HALT) ? halt_cycles + 1 : 0;
        end

        // Drain with no backpressure and no new traffic
        rand_mode = 1'b0;
        full_next = '0;
        repeat (20) run_cycle();
        @(negedge clk);
        #1;
        compare("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
